// File: rtl/disaggregator_pkg.sv
// ============================================================================
// disaggregator_pkg : shared defaults and index type for the wide-to-narrow path
// Revision: 1.0
// ============================================================================
`default_nettype none

package disaggregator_pkg;

  localparam int DSIZE       = 11;
  localparam int FETCH_WIDTH = 2;

  // A one-slice word still needs a 1-bit index so the counter never collapses to zero width.
  function automatic int idx_width(input int fetch_width);
    return (fetch_width > 1) ? $clog2(fetch_width) : 1;
  endfunction

  localparam int FETCH_IDX_W = idx_width(FETCH_WIDTH);

  typedef logic [FETCH_IDX_W-1:0] fetch_idx_t;

endpackage

`default_nettype wire

// File: rtl/disaggregator_if.sv
// ============================================================================
// disaggregator_if : FWFT sender side plus narrow receiver side of the serializer
// Revision: 1.0
// ============================================================================
`default_nettype none

interface disaggregator_if
  import disaggregator_pkg::*;
#(
  parameter int DATA_WIDTH  = DSIZE,
  parameter int FETCH_WIDTH = disaggregator_pkg::FETCH_WIDTH
);

  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data;
  logic                              sender_empty_n;
  logic                              sender_deq;
  logic [DATA_WIDTH-1:0]             receiver_data;
  logic                              receiver_full_n;
  logic                              receiver_enq;

  // Environment view: feeds the wide sender and models the narrow receiver.
  modport master (
    output sender_data,
    output sender_empty_n,
    input  sender_deq,
    input  receiver_data,
    output receiver_full_n,
    input  receiver_enq
  );

  // Serializer view.
  modport slave (
    input  sender_data,
    input  sender_empty_n,
    output sender_deq,
    output receiver_data,
    input  receiver_full_n,
    output receiver_enq
  );

endinterface

`default_nettype wire

// File: rtl/disaggregator.sv
// ============================================================================
// disaggregator : splits FETCH_WIDTH*DATA_WIDTH words into DATA_WIDTH slices, LSB slice first
// Revision: 1.0
// ============================================================================
`default_nettype none

module disaggregator
  import disaggregator_pkg::*;
#(
  parameter int DATA_WIDTH  = DSIZE,
  parameter int FETCH_WIDTH = disaggregator_pkg::FETCH_WIDTH
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  disaggregator_if.slave bus
);

  localparam int                WIDE_W   = FETCH_WIDTH * DATA_WIDTH;
  localparam int                IDX_W    = idx_width(FETCH_WIDTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FETCH_WIDTH - 1);

  logic [WIDE_W-1:0]     r_cur_data;
  logic [WIDE_W-1:0]     r_nxt_data;
  logic                  r_cur_v;
  logic                  r_nxt_v;
  logic [IDX_W-1:0]      r_idx;

  logic [DATA_WIDTH-1:0] w_slice [FETCH_WIDTH];
  logic [DATA_WIDTH-1:0] w_rx_data;
  logic                  w_enq;
  logic                  w_deq;
  logic                  w_finish;

  genvar gi;
  generate
    for (gi = 0; gi < FETCH_WIDTH; gi++) begin : g_slice
      assign w_slice[gi] = r_cur_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  always_comb begin
    w_rx_data = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_rx_data = w_slice[i];
      end
    end
  end

  assign w_enq    = r_cur_v & bus.receiver_full_n;
  assign w_finish = w_enq & (r_idx == LAST_IDX);
  // Pop only while nxt is free; gated by rst_n so nothing is lost while reset is held.
  assign w_deq    = rst_n & bus.sender_empty_n & ~r_nxt_v;

  assign bus.receiver_enq  = w_enq;
  assign bus.receiver_data = w_rx_data;
  assign bus.sender_deq    = w_deq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_data <= '0;
      r_nxt_data <= '0;
      r_cur_v    <= 1'b0;
      r_nxt_v    <= 1'b0;
      r_idx      <= '0;
    end else if (w_finish) begin
      r_idx <= '0;
      if (r_nxt_v) begin
        r_cur_data <= r_nxt_data;
        r_nxt_v    <= 1'b0;
      end else if (w_deq) begin
        // Direct load on the last slice keeps the narrow stream bubble-free.
        r_cur_data <= bus.sender_data;
      end else begin
        r_cur_v <= 1'b0;
      end
    end else begin
      if (w_enq) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_deq) begin
        if (!r_cur_v) begin
          r_cur_data <= bus.sender_data;
          r_cur_v    <= 1'b1;
          r_idx      <= '0;
        end else begin
          r_nxt_data <= bus.sender_data;
          r_nxt_v    <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_disaggregator.sv
// ============================================================================
// tb_disaggregator : directed checks of the serializer at FETCH_WIDTH=2 and FETCH_WIDTH=1
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_disaggregator;
  import disaggregator_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  disaggregator_if #(.DATA_WIDTH(11), .FETCH_WIDTH(2)) sif ();
  disaggregator_if #(.DATA_WIDTH(11), .FETCH_WIDTH(1)) sif1 ();

  disaggregator #(.DATA_WIDTH(11), .FETCH_WIDTH(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  disaggregator #(.DATA_WIDTH(11), .FETCH_WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif1)
  );

  int checks = 0;
  int errors = 0;

  logic [21:0] q2 [$];
  logic [10:0] q1 [$];

  // Expected per-cycle tables: enq, data, deq.
  logic        s_enq [8]  = '{0, 1, 1, 1, 1, 1, 1, 0};
  int          s_dat [8]  = '{0, 1, 2, 3, 4, 5, 6, 0};
  logic        s_deq [8]  = '{1, 1, 0, 1, 0, 0, 0, 0};

  logic        b_full [13] = '{1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
  logic        b_enq  [13] = '{0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0};
  int          b_dat  [13] = '{0, 1, 2, 2, 2, 2, 2, 2, 3, 4, 5, 6, 0};
  logic        b_deq  [13] = '{1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};

  logic        f_enq [6]  = '{0, 1, 1, 1, 1, 0};
  int          f_dat [6]  = '{0, 7, 8, 9, 10, 0};
  logic        f_deq [6]  = '{1, 1, 1, 1, 0, 0};

  function automatic logic [21:0] w2(input int hi, input int lo);
    return {11'(hi), 11'(lo)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive();
    sif.sender_empty_n  = (q2.size() != 0);
    sif.sender_data     = (q2.size() != 0) ? q2[0] : '0;
    sif1.sender_empty_n = (q1.size() != 0);
    sif1.sender_data    = (q1.size() != 0) ? q1[0] : '0;
    #1;
  endtask

  // Sender model: the head pops when deq was high at the edge.
  task automatic tick();
    logic d2;
    logic d1;
    d2 = sif.sender_deq;
    d1 = sif1.sender_deq;
    @(posedge clk);
    #1;
    if (d2 && q2.size() != 0) void'(q2.pop_front());
    if (d1 && q1.size() != 0) void'(q1.pop_front());
    drive();
  endtask

  task automatic exp2(input string tag, input logic enq, input int data, input logic deq);
    chk({tag, "_enq"}, 32'(sif.receiver_enq), 32'(enq));
    if (enq) chk({tag, "_data"}, 32'(sif.receiver_data), 32'(data));
    chk({tag, "_deq"}, 32'(sif.sender_deq), 32'(deq));
  endtask

  initial begin
    sif.receiver_full_n  = 1'b1;
    sif1.receiver_full_n = 1'b1;
    rst_n = 1'b0;
    q2.push_back(w2(2, 1));
    drive();
    repeat (2) tick();

    chk("rst_deq",   32'(sif.sender_deq),     32'd0);
    chk("rst_enq",   32'(sif.receiver_enq),   32'd0);
    chk("rst_data",  32'(sif.receiver_data),  32'd0);
    chk("rst1_enq",  32'(sif1.receiver_enq),  32'd0);
    chk("rst1_data", 32'(sif1.receiver_data), 32'd0);

    // Single word {2,1}
    rst_n = 1'b1;
    drive();
    exp2("single_c0", 1'b0, 0, 1'b1);
    tick();
    exp2("single_c1", 1'b1, 1, 1'b0);
    tick();
    exp2("single_c2", 1'b1, 2, 1'b0);
    tick();
    exp2("single_c3", 1'b0, 0, 1'b0);

    // Back-to-back stream of three words
    q2.push_back(w2(2, 1));
    q2.push_back(w2(4, 3));
    q2.push_back(w2(6, 5));
    drive();
    for (int i = 0; i < 8; i++) begin
      exp2($sformatf("stream_c%0d", i), s_enq[i], s_dat[i], s_deq[i]);
      tick();
    end

    // Receiver backpressure after the first slice
    q2.push_back(w2(2, 1));
    q2.push_back(w2(4, 3));
    q2.push_back(w2(6, 5));
    for (int i = 0; i < 13; i++) begin
      sif.receiver_full_n = b_full[i];
      drive();
      exp2($sformatf("bp_c%0d", i), b_enq[i], b_dat[i], b_deq[i]);
      if (!b_full[i]) chk($sformatf("bp_hold_c%0d", i), 32'(sif.receiver_data), 32'd2);
      tick();
    end
    sif.receiver_full_n = 1'b1;

    // FETCH_WIDTH=1: one slice per word, no bubbles
    q1.push_back(11'd7);
    q1.push_back(11'd8);
    q1.push_back(11'd9);
    q1.push_back(11'd10);
    drive();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("fw1_c%0d_enq", i), 32'(sif1.receiver_enq), 32'(f_enq[i]));
      if (f_enq[i]) chk($sformatf("fw1_c%0d_data", i), 32'(sif1.receiver_data), 32'(f_dat[i]));
      chk($sformatf("fw1_c%0d_deq", i), 32'(sif1.sender_deq), 32'(f_deq[i]));
      tick();
    end

    // Reset in the middle of a word discards its remaining slice
    q2.push_back(w2(2, 1));
    drive();
    exp2("mrst_c0", 1'b0, 0, 1'b1);
    tick();
    exp2("mrst_c1", 1'b1, 1, 1'b0);
    rst_n = 1'b0;
    drive();
    chk("mrst_hold_enq",  32'(sif.receiver_enq),  32'd0);
    chk("mrst_hold_data", 32'(sif.receiver_data), 32'd0);
    tick();
    chk("mrst_hold2_enq", 32'(sif.receiver_enq),  32'd0);
    rst_n = 1'b1;
    q2.push_back(w2(4, 3));
    drive();
    exp2("mrst_c2", 1'b0, 0, 1'b1);
    tick();
    exp2("mrst_c3", 1'b1, 3, 1'b0);
    tick();
    exp2("mrst_c4", 1'b1, 4, 1'b0);
    tick();
    exp2("mrst_c5", 1'b0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
